alarm_timekeeper: RTL and testbench
===================================

# alarm_timekeeper

Time-of-day source for the alarm design: divides the system clock down to a 1 Hz tick and maintains a BCD hours/minutes/seconds count. Sits directly upstream of the alarm comparator and display logic in the tt_um_haoyang_alarm top level, which consume its BCD time and its minute-rollover strobe. It also provides a user set mode for adjusting hours and minutes from button pulses; these pulses are already debounced upstream.

## Interface
- CLK_HZ, 10_000_000: system clock frequency. The prescaler divides by exactly CLK_HZ. Must be ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ena  in  1  design enable. When low, all state is frozen and strobes are 0.
- set_en  in  1  set mode. When high, the clock is stopped and the increment inputs are honoured.
- hour_inc  in  1  single-cycle pulse that increments hours; honoured only when set_en=1.
- min_inc  in  1  single-cycle pulse that increments minutes; honoured only when set_en=1.
- hh  out  8  hours in BCD: {tens[7:4], units[3:0]}.
- mm  out  8  minutes in BCD.
- ss  out  8  seconds in BCD.
- pm  out  1  PM flag. Only meaningful when TWELVE_HOUR_EN is defined; otherwise tied to 0.
- sec_tick  out  1  one-cycle strobe on each seconds increment.
- min_tick  out  1  one-cycle strobe on each 59→00 seconds rollover (the new-minute strobe for the alarm comparator).

## Operation
- Prescaler: counter of width $clog2(CLK_HZ).
  - Counts from 0 to CLK_HZ-1, then wraps to 0.
  - sec_tick=1 combinationally during the cycle in which the prescaler = CLK_HZ-1 and ena=1 and set_en=0.
- Time counters are BCD digit counters with no binary-to-BCD conversion. On an edge where sec_tick=1:
  - ss increments.
  - When ss is 59: ss wraps to 00 and mm increments.
  - When mm is also 59: mm wraps to 00 and hh increments.
  - 24-hour sequence: 00→23→00.
- min_tick=1 exactly when sec_tick=1 and ss=59.
- Set mode (set_en=1):
  - Prescaler is held at 0 and ss is forced to 00.
  - sec_tick and min_tick are 0.
  - hour_inc increments hh with wrap and no effect on mm.
  - min_inc increments mm with wrap 59→00 and no carry into hh.
  - If hour_inc and min_inc are both high in the same cycle, both apply.
  - Increment inputs are ignored when set_en=0 or ena=0.
- Leaving set mode (set_en falls): counting resumes with the prescaler at 0. The first sec_tick occurs CLK_HZ cycles after the first cycle in which set_en=0.
- ena=0: prescaler, counters and pm all hold their values; strobes are 0. This takes priority over set_en.
- Reset values:
  - Prescaler 0.
  - hh=00 (12-hour build: 12), mm=00, ss=00.
  - pm=0, sec_tick=0, min_tick=0.
  - Reset asserted mid-count discards the partial prescale.

## Timing
- sec_tick and min_tick are valid combinationally in the cycle before the time outputs change.
- hh, mm and ss are registered and update on the clock edge that ends the strobe cycle.
- Downstream consumers sample the new time on the cycle after min_tick.
- Increment latency: an increment pulse in cycle N is visible on hh/mm in cycle N+1.
- A pulse held high for k cycles increments k times (level-per-cycle behaviour, not edge-detected).
- Tick period is exactly CLK_HZ cycles while ena=1 and set_en=0, with no drift.

## Configuration
- TWELVE_HOUR_EN defined:
  - Hour sequence is 12, 01, 02, …, 11, 12.
  - The 11→12 transition toggles pm. The 12→01 transition does not.
  - Applies both to rollover from mm and to hour_inc.
  - Reset value is 12:00:00 with pm=0.
- TWELVE_HOUR_EN undefined:
  - Hour sequence is 00–23.
  - pm is constant 0.

## Test plan
- Reset hold and release, CLK_HZ=4:
  - Outputs are 00:00:00 with all strobes 0.
  - First sec_tick occurs at the 4th cycle after release.
  - ss=01 appears on the following cycle.
- Full rollover, CLK_HZ=4: set mode to 23:59, release set_en, run 60 ticks.
  - min_tick fires together with the 60th sec_tick.
  - Next cycle shows 00:00:00.
- Set mode increments:
  - mm=58, then min_inc pulsed 3 times → mm=01 with hh unchanged.
  - Simultaneous hour_inc and min_inc from 05:10 → 06:11.
  - Increments with set_en=0 have no effect.
- Freeze: drop ena for 10 cycles mid-prescale.
  - No strobes while ena=0.
  - Tick is delayed by exactly 10 cycles; counter values are held.
- Asynchronous reset mid-operation: assert reset between clock edges at 07:33:21.
  - Outputs go to 00:00:00 without waiting for a clock edge.
- TWELVE_HOUR_EN build:
  - From reset, hour_inc ×11 → 11, pm=0.
  - One more → 12, pm=1.
  - One more → 01, pm=1.

Source files
------------

// File: rtl/alarm_timekeeper.sv
// Time-of-day counter for the alarm: CLK_HZ prescaler to a 1 Hz tick, BCD hh:mm:ss, set mode.
// Optional feature: define TWELVE_HOUR_EN for a 12..11 hour sequence with a PM flag.
module alarm_timekeeper #(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       set_en,
  input  logic       hour_inc,
  input  logic       min_inc,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

`ifdef TWELVE_HOUR_EN
  localparam logic [7:0] HOUR_RST  = 8'h12;
  localparam logic [7:0] HOUR_TOP  = 8'h12;
  localparam logic [7:0] HOUR_WRAP = 8'h01;
`else
  localparam logic [7:0] HOUR_RST  = 8'h00;
  localparam logic [7:0] HOUR_TOP  = 8'h23;
  localparam logic [7:0] HOUR_WRAP = 8'h00;
`endif

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    hh_q, hh_d;
  logic [7:0]    mm_q, mm_d;
  logic [7:0]    ss_q, ss_d;
  logic          hour_step;

  // One BCD step with units carrying into tens; callers handle the wrap point.
  function automatic logic [7:0] bcd_step(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v == 8'h59) return 8'h00;
    else            return bcd_step(v);
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v == HOUR_TOP) return HOUR_WRAP;
    else               return bcd_step(v);
  endfunction

  assign sec_tick = ena & ~set_en & (pre_q == PRE_MAX);
  assign min_tick = sec_tick & (ss_q == 8'h59);

  always_comb begin
    pre_d     = pre_q;
    hh_d      = hh_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    hour_step = 1'b0;
    if (ena) begin
      if (set_en) begin
        pre_d = '0;
        ss_d  = 8'h00;
        if (min_inc) mm_d = inc60(mm_q);
        hour_step = hour_inc;
      end else begin
        pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        if (sec_tick) begin
          ss_d = inc60(ss_q);
          if (ss_q == 8'h59) begin
            mm_d = inc60(mm_q);
            hour_step = (mm_q == 8'h59);
          end
        end
      end
    end
    if (hour_step) hh_d = inc_hour(hh_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      hh_q  <= HOUR_RST;
      mm_q  <= 8'h00;
      ss_q  <= 8'h00;
    end else begin
      pre_q <= pre_d;
      hh_q  <= hh_d;
      mm_q  <= mm_d;
      ss_q  <= ss_d;
    end
  end

`ifdef TWELVE_HOUR_EN
  logic pm_q, pm_d;

  // PM flips only on 11 -> 12, whether reached by rollover or by hour_inc.
  assign pm_d = pm_q ^ (hour_step & (hh_q == 8'h11));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pm_q <= 1'b0;
    else        pm_q <= pm_d;
  end

  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

  assign hh = hh_q;
  assign mm = mm_q;
  assign ss = ss_q;

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Directed bench for alarm_timekeeper at CLK_HZ=4; covers TWELVE_HOUR_EN when defined.
module tb_alarm_timekeeper;

  localparam int CLK_HZ = 4;

`ifdef TWELVE_HOUR_EN
  localparam logic [7:0] HH_RST   = 8'h12;
  localparam int         LAST_H   = 11;
  localparam logic [7:0] HH_LAST  = 8'h11;
  localparam logic [7:0] HH_WRAP  = 8'h12;
  localparam logic       PM_WRAP  = 1'b1;
`else
  localparam logic [7:0] HH_RST   = 8'h00;
  localparam int         LAST_H   = 23;
  localparam logic [7:0] HH_LAST  = 8'h23;
  localparam logic [7:0] HH_WRAP  = 8'h00;
  localparam logic       PM_WRAP  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b1;
  logic       set_en = 1'b0;
  logic       hour_inc = 1'b0;
  logic       min_inc = 1'b0;
  logic [7:0] hh, mm, ss;
  logic       pm, sec_tick, min_tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alarm_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .set_en   (set_en),
    .hour_inc (hour_inc),
    .min_inc  (min_inc),
    .hh       (hh),
    .mm       (mm),
    .ss       (ss),
    .pm       (pm),
    .sec_tick (sec_tick),
    .min_tick (min_tick)
  );

  // Sample point: 1 time unit after the falling edge, well away from the rising edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Asynchronous reset pulse; returns in the first cycle after release (prescaler 0).
  task automatic do_reset();
    set_en = 1'b0; hour_inc = 1'b0; min_inc = 1'b0; ena = 1'b1;
    reset = 1'b0;
    #3;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  // Enters set mode and applies h hour and m minute increments, one per cycle.
  task automatic set_time(input int h, input int m);
    int n;
    n = (h > m) ? h : m;
    set_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      hour_inc = (i < h);
      min_inc  = (i < m);
      cyc();
    end
    hour_inc = 1'b0;
    min_inc  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc();
    n_checks++;
    if ({hh, mm, ss} !== {HH_RST, 16'h0000}) begin
      n_fail++; $display("FAIL reset_time: got %h expected %h", {hh, mm, ss}, {HH_RST, 16'h0000});
    end
    n_checks++;
    if ({pm, sec_tick, min_tick} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {pm, sec_tick, min_tick});
    end
    reset = 1'b1;
    #1;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) cyc();
      n_checks++;
      if (sec_tick !== (c == 4)) begin
        n_fail++; $display("FAIL reset_first_tick c=%0d: got %b expected %b", c, sec_tick, (c == 4));
      end
      n_checks++;
      if (ss !== ((c == 5) ? 8'h01 : 8'h00)) begin
        n_fail++; $display("FAIL reset_ss c=%0d: got %h expected %h", c, ss, ((c == 5) ? 8'h01 : 8'h00));
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_rollover();
    do_reset();
    set_time(LAST_H, 59);
    n_checks++;
    if ({hh, mm, ss} !== {HH_LAST, 16'h5900}) begin
      n_fail++; $display("FAIL roll_setup: got %h expected %h", {hh, mm, ss}, {HH_LAST, 16'h5900});
    end
    set_en = 1'b0;
    #1;
    for (int c = 1; c <= 241; c++) begin
      if (c > 1) cyc();
      if (c <= 240) begin
        n_checks++;
        if (sec_tick !== (c % 4 == 0)) begin
          n_fail++; $display("FAIL roll_sec_tick c=%0d: got %b expected %b", c, sec_tick, (c % 4 == 0));
        end
        n_checks++;
        if (min_tick !== (c == 240)) begin
          n_fail++; $display("FAIL roll_min_tick c=%0d: got %b expected %b", c, min_tick, (c == 240));
        end
      end
      if (c == 240) begin
        n_checks++;
        if ({hh, mm, ss} !== {HH_LAST, 16'h5959}) begin
          n_fail++; $display("FAIL roll_pre: got %h expected %h", {hh, mm, ss}, {HH_LAST, 16'h5959});
        end
      end
    end
    n_checks++;
    if ({hh, mm, ss, pm} !== {HH_WRAP, 16'h0000, PM_WRAP}) begin
      n_fail++; $display("FAIL roll_post: got %h expected %h", {hh, mm, ss, pm}, {HH_WRAP, 16'h0000, PM_WRAP});
    end
    $display("test_rollover done");
  endtask

  task automatic test_set_mode();
    logic [7:0] exp_m [3];
    exp_m = '{8'h59, 8'h00, 8'h01};
    do_reset();
    set_time(0, 58);
    n_checks++;
    if ({hh, mm} !== {HH_RST, 8'h58}) begin
      n_fail++; $display("FAIL set_mm58: got %h expected %h", {hh, mm}, {HH_RST, 8'h58});
    end
    for (int k = 0; k < 3; k++) begin
      min_inc = 1'b1;
      cyc();
      min_inc = 1'b0;
      #1;
      n_checks++;
      if ({hh, mm} !== {HH_RST, exp_m[k]}) begin
        n_fail++; $display("FAIL set_min_pulse k=%0d: got %h expected %h", k, {hh, mm}, {HH_RST, exp_m[k]});
      end
      cyc();
    end

    do_reset();
    set_time(5, 10);
    n_checks++;
    if ({hh, mm} !== 16'h0510) begin
      n_fail++; $display("FAIL set_0510: got %h expected 0510", {hh, mm});
    end
    hour_inc = 1'b1; min_inc = 1'b1;
    cyc();
    hour_inc = 1'b0; min_inc = 1'b0;
    #1;
    n_checks++;
    if ({hh, mm, ss} !== 24'h061100) begin
      n_fail++; $display("FAIL set_both: got %h expected 061100", {hh, mm, ss});
    end
    set_en = 1'b0; hour_inc = 1'b1; min_inc = 1'b1;
    cyc(); cyc();
    hour_inc = 1'b0; min_inc = 1'b0;
    #1;
    n_checks++;
    if ({hh, mm} !== 16'h0611) begin
      n_fail++; $display("FAIL inc_ignored_run: got %h expected 0611", {hh, mm});
    end
    ena = 1'b0; set_en = 1'b1; hour_inc = 1'b1; min_inc = 1'b1;
    cyc(); cyc();
    hour_inc = 1'b0; min_inc = 1'b0; ena = 1'b1; set_en = 1'b0;
    #1;
    n_checks++;
    if ({hh, mm} !== 16'h0611) begin
      n_fail++; $display("FAIL inc_ignored_ena: got %h expected 0611", {hh, mm});
    end

    do_reset();
    for (int c = 2; c <= 5; c++) cyc();
    n_checks++;
    if (ss !== 8'h01) begin
      n_fail++; $display("FAIL set_pre_ss: got %h expected 01", ss);
    end
    set_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      n_checks++;
      if ({ss, sec_tick, min_tick} !== 10'b0) begin
        n_fail++; $display("FAIL set_ss_forced c=%0d: got %h/%b%b expected 00/00", c, ss, sec_tick, min_tick);
      end
    end
    set_en = 1'b0;
    $display("test_set_mode done");
  endtask

  task automatic test_freeze();
    do_reset();
    for (int c = 2; c <= 15; c++) begin
      cyc();
      if (c == 4)  begin ena = 1'b0; #1; end
      if (c == 14) begin ena = 1'b1; #1; end
      n_checks++;
      if ({sec_tick, min_tick} !== {(c == 14), 1'b0}) begin
        n_fail++; $display("FAIL freeze_tick c=%0d: got %b%b expected %b0", c, sec_tick, min_tick, (c == 14));
      end
      n_checks++;
      if (ss !== ((c == 15) ? 8'h01 : 8'h00)) begin
        n_fail++; $display("FAIL freeze_ss c=%0d: got %h expected %h", c, ss, ((c == 15) ? 8'h01 : 8'h00));
      end
    end
    $display("test_freeze done");
  endtask

  task automatic test_async_reset();
    do_reset();
    set_time(7, 33);
    set_en = 1'b0;
    #1;
    for (int c = 2; c <= 85; c++) cyc();
    n_checks++;
    if ({hh, mm, ss} !== 24'h073321) begin
      n_fail++; $display("FAIL async_pre: got %h expected 073321", {hh, mm, ss});
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({hh, mm, ss} !== {HH_RST, 16'h0000}) begin
      n_fail++; $display("FAIL async_time: got %h expected %h", {hh, mm, ss}, {HH_RST, 16'h0000});
    end
    n_checks++;
    if ({pm, sec_tick, min_tick} !== 3'b000) begin
      n_fail++; $display("FAIL async_flags: got %b expected 000", {pm, sec_tick, min_tick});
    end
    cyc();
    reset = 1'b1;
    $display("test_async_reset done");
  endtask

  task automatic test_hours();
    do_reset();
`ifdef TWELVE_HOUR_EN
    set_time(11, 0);
    n_checks++;
    if ({hh, pm} !== {8'h11, 1'b0}) begin
      n_fail++; $display("FAIL h12_11: got %h/%b expected 11/0", hh, pm);
    end
    hour_inc = 1'b1; cyc(); hour_inc = 1'b0; #1;
    n_checks++;
    if ({hh, pm} !== {8'h12, 1'b1}) begin
      n_fail++; $display("FAIL h12_12: got %h/%b expected 12/1", hh, pm);
    end
    hour_inc = 1'b1; cyc(); hour_inc = 1'b0; #1;
    n_checks++;
    if ({hh, pm} !== {8'h01, 1'b1}) begin
      n_fail++; $display("FAIL h12_01: got %h/%b expected 01/1", hh, pm);
    end
`else
    set_time(10, 0);
    n_checks++;
    if (hh !== 8'h10) begin
      n_fail++; $display("FAIL h24_10: got %h expected 10", hh);
    end
    set_time(13, 0);
    n_checks++;
    if (hh !== 8'h23) begin
      n_fail++; $display("FAIL h24_23: got %h expected 23", hh);
    end
    hour_inc = 1'b1; cyc(); hour_inc = 1'b0; #1;
    n_checks++;
    if ({hh, mm, pm} !== {16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL h24_wrap: got %h/%h/%b expected 00/00/0", hh, mm, pm);
    end
`endif
    set_en = 1'b0;
    $display("test_hours done");
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_set_mode();
    test_freeze();
    test_async_reset();
    test_hours();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
